// File: rtl/pri_arbiter_8.sv
// pri_arbiter_8: 8-requester arbiter with fixed-priority or round-robin selection,
// grant hold until release, and a hold limit that forces rotation.
module pri_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         gnt_id_q, gnt_id_d;
    logic [7:0]         gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [2:0]         rr_start_q, rr_start_d;

    logic               holder_req;
    logic               at_limit;
    logic [2:0]         rr_next;
    logic [2:0]         search_start;
    logic [7:0]         eligible;
    logic [3:0]         pick;

    // Returns {found, index}. Fixed mode favours the highest bit; round-robin
    // favours start, start-1, ... wrapping mod 8.
    function automatic logic [3:0] arbitrate(input logic [7:0] r,
                                             input logic       md,
                                             input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        idx = 3'd0;
        if (!md) begin
            for (int i = 0; i < 8; i++) begin
                if (r[i]) res = {1'b1, 3'(i)};
            end
        end else begin
            for (int k = 7; k >= 0; k--) begin
                idx = start - 3'(k);
                if (r[idx]) res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign holder_req = req[gnt_id_q];
    assign at_limit   = (hold_cnt_q >= CNT_W'(MAX_HOLD));
    assign rr_next    = gnt_id_q - 3'd1;

    // The round-robin pointer moves past the outgoing holder before the
    // same-edge re-arbitration, so the next search starts just below it.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        eligible     = req;
        search_start = rr_start_q;
        if (state_q == GRANT) begin
            search_start = rr_next;
            if (holder_req) eligible = req & ~(8'd1 << gnt_id_q);
        end
    end

    assign pick = arbitrate(eligible, mode, search_start);

    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        hold_cnt_d = hold_cnt_q;
        rr_start_d = rr_start_q;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick[3]) begin
                    state_d    = GRANT;
                    gnt_id_d   = pick[2:0];
                    hold_cnt_d = CNT_W'(1);
                end
            end
            GRANT: begin
                if (holder_req && !at_limit) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end else begin
                    rr_start_d = rr_next;
                    timeout_d  = holder_req;
                    if (pick[3]) begin
                        gnt_id_d   = pick[2:0];
                        hold_cnt_d = CNT_W'(1);
                    end else begin
                        state_d    = IDLE;
                        gnt_id_d   = 3'd0;
                        hold_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt_valid_d = (state_d == GRANT);
        gnt_d       = gnt_valid_d ? (8'd1 << gnt_id_d) : 8'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_id_q    <= 3'd0;
            gnt_q       <= 8'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            rr_start_q  <= 3'd7;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            rr_start_q  <= rr_start_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
